line_write_buffer: RTL and testbench

- Posted write-back buffer between the direct-mapped cache controller (mem_req_* side) and the memory model.
- Absorbs dirty-line evictions so a miss-with-writeback needs only one memory read before the refill completes.
- Drains queued lines to memory in the background.
- Presents the memory-style handshake upstream and the controller-style handshake downstream.

---
 rtl/line_write_buffer_if.sv | 33 +++
 rtl/line_write_buffer.sv | 182 ++++++++++++++++++
 tb/tb_line_write_buffer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_write_buffer_if.sv
// Handshake bundle between the cache controller, the write-back buffer and memory.
// The slave modport is the buffer's view; master is the environment's view.
interface line_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              cache_req_valid_i;
    logic              cache_req_rw_i;
    logic [ADDR_W-1:0] cache_req_addr_i;
    logic [LINE_W-1:0] cache_req_data_i;
    logic              cache_ready_o;
    logic [LINE_W-1:0] cache_data_o;
    logic              mem_req_valid_o;
    logic              mem_req_rw_o;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic [LINE_W-1:0] mem_req_data_o;
    logic              mem_ready_i;
    logic [LINE_W-1:0] mem_data_i;

    modport slave (
        input  cache_req_valid_i, cache_req_rw_i, cache_req_addr_i, cache_req_data_i,
        input  mem_ready_i, mem_data_i,
        output cache_ready_o, cache_data_o,
        output mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o
    );

    modport master (
        output cache_req_valid_i, cache_req_rw_i, cache_req_addr_i, cache_req_data_i,
        output mem_ready_i, mem_data_i,
        input  cache_ready_o, cache_data_o,
        input  mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o
    );
endinterface

// File: rtl/line_write_buffer.sv
// Posted write-back line buffer: absorbs evictions, coalesces same-line writes, drains in background.
// Define WB_FORWARD_EN to let reads hit queued lines and bypass queued writes on a miss.
module line_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    line_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LA_W  = ADDR_W - 4;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef enum logic [1:0] {M_IDLE, M_RD, M_WR} mstate_t;

    logic [LA_W-1:0]   r_ent_addr [DEPTH];
    logic [LINE_W-1:0] r_ent_data [DEPTH];
    logic [PTR_W-1:0]  r_head, r_tail;
    logic [PTR_W:0]    r_count;
    mstate_t           r_mstate, w_mstate_next;
    logic              r_rd_pend;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_cache_ready;
    logic [LINE_W-1:0] r_cache_data;
    logic              r_mem_valid, r_mem_rw;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_data;

    logic              w_sample, w_pop, w_start_rd, w_start_wr, w_head_busy;
    logic              w_not_full, w_wr_ok, w_append, w_coal, w_coal_hit;
    logic              w_rd_hit, w_rd_miss, w_rd_done;
    logic [PTR_W-1:0]  w_coal_idx;
    logic [LINE_W-1:0] w_fwd_data;
    logic [LA_W-1:0]   w_req_la;
    logic [PTR_W-1:0]  w_off [DEPTH];
    logic [DEPTH-1:0]  w_match;

    assign w_req_la    = bus.cache_req_addr_i[ADDR_W-1:4];
    assign w_sample    = bus.cache_req_valid_i && !r_rd_pend && !r_cache_ready;
    assign w_pop       = (r_mstate == M_WR) && bus.mem_ready_i;
    assign w_rd_done   = (r_mstate == M_RD) && bus.mem_ready_i;
    assign w_not_full  = r_count < (PTR_W+1)'(DEPTH);
    assign w_head_busy = (r_mstate == M_WR) || w_start_wr;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign w_off[gi]   = PTR_W'(gi) - r_head;
            assign w_match[gi] = ({1'b0, w_off[gi]} < r_count) && (r_ent_addr[gi] == w_req_la);
        end
    endgenerate

    // The in-flight head is already latched into the memory request, so it must not be modified.
    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match[k] && !((PTR_W'(k) == r_head) && w_head_busy)) begin
                w_coal_hit = 1'b1;
                w_coal_idx = PTR_W'(k);
            end
        end
    end

`ifdef WB_FORWARD_EN
    logic             w_fwd_hit;
    logic [PTR_W-1:0] w_fwd_idx;
    // Walk from oldest to youngest so the last match wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_idx = r_head + PTR_W'(k);
            if (w_match[w_fwd_idx]) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_ent_data[w_fwd_idx];
            end
        end
    end
    assign w_rd_hit = w_sample && !bus.cache_req_rw_i && w_fwd_hit;
`else
    assign w_fwd_data = '0;
    assign w_rd_hit   = 1'b0;
`endif

    assign w_wr_ok   = w_sample && bus.cache_req_rw_i && w_not_full;
    assign w_append  = w_wr_ok && !w_coal_hit;
    assign w_coal    = w_wr_ok && w_coal_hit;
    assign w_rd_miss = w_sample && !bus.cache_req_rw_i && !w_rd_hit;

    always_comb begin
        w_mstate_next = r_mstate;
        w_start_rd    = 1'b0;
        w_start_wr    = 1'b0;
        case (r_mstate)
            M_IDLE: begin
                if (r_rd_pend && (FWD || (r_count == '0))) begin
                    w_mstate_next = M_RD;
                    w_start_rd    = 1'b1;
                end else if (r_count != '0) begin
                    w_mstate_next = M_WR;
                    w_start_wr    = 1'b1;
                end
            end
            M_RD:    if (bus.mem_ready_i) w_mstate_next = M_IDLE;
            M_WR:    if (bus.mem_ready_i) w_mstate_next = M_IDLE;
            default: w_mstate_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mstate <= M_IDLE;
        else     r_mstate <= w_mstate_next;
    end

    // Line storage carries no reset; r_count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_append) begin
            r_ent_addr[r_tail] <= w_req_la;
            r_ent_data[r_tail] <= bus.cache_req_data_i;
        end else if (w_coal) begin
            r_ent_data[w_coal_idx] <= bus.cache_req_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_rd_pend     <= 1'b0;
            r_rd_addr     <= '0;
            r_cache_ready <= 1'b0;
            r_cache_data  <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_rw      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data    <= '0;
        end else begin
            if (w_append) r_tail <= r_tail + 1'b1;
            if (w_pop)    r_head <= r_head + 1'b1;
            case ({w_append, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_rd_miss) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= bus.cache_req_addr_i;
            end else if (w_rd_done) begin
                r_rd_pend <= 1'b0;
            end

            r_cache_ready <= w_wr_ok || w_rd_hit || w_rd_done;
            if (w_rd_hit)       r_cache_data <= w_fwd_data;
            else if (w_rd_done) r_cache_data <= bus.mem_data_i;

            if (w_start_wr || w_start_rd) begin
                r_mem_valid <= 1'b1;
                r_mem_rw    <= w_start_wr;
                r_mem_addr  <= w_start_wr ? {r_ent_addr[r_head], 4'b0000} : r_rd_addr;
                r_mem_data  <= r_ent_data[r_head];
            end else if (bus.mem_ready_i && (r_mstate != M_IDLE)) begin
                r_mem_valid <= 1'b0;
            end
        end
    end

    assign bus.cache_ready_o   = r_cache_ready;
    assign bus.cache_data_o    = r_cache_data;
    assign bus.mem_req_valid_o = r_mem_valid;
    assign bus.mem_req_rw_o    = r_mem_rw;
    assign bus.mem_req_addr_o  = r_mem_addr;
    assign bus.mem_req_data_o  = r_mem_data;
endmodule

// File: tb/tb_line_write_buffer.sv
// Scoreboard bench for line_write_buffer: directed cache ops, a delayed memory model,
// and monitors that compare every cache completion and memory transaction against queues.
module tb_line_write_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_write_buffer_if bus ();
    line_write_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit           is_rd;
        logic [127:0] data;
        string        name;
    } cache_exp_t;
    typedef struct {
        bit           rw;
        logic [31:0]  addr;
        logic [127:0] data;
    } mem_exp_t;

    cache_exp_t   cache_q[$];
    mem_exp_t     mem_q[$];
    logic [127:0] ref_mem   [int];
    logic [127:0] mem_store [int];
    int n_checks = 0;
    int n_fail   = 0;
    int mem_delay = 1;
    int mem_cnt = 0;
    bit mem_active = 0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dflt(input int line);
        return {4{32'hdead_0000 | line}};
    endfunction

    // Memory model: accepts a request after mem_delay cycles and checks it against mem_q.
    initial begin : mem_model
        mem_mon_t_init();
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.mem_ready_i = 1'b0;
                mem_active = 0;
                mem_cnt = 0;
            end else if (bus.mem_ready_i) begin
                bus.mem_ready_i = 1'b0;
                mem_active = 0;
            end else begin
                if (!mem_active && bus.mem_req_valid_o) begin
                    mem_active = 1;
                    mem_cnt = mem_delay;
                end
                if (mem_active) begin
                    if (mem_cnt <= 1) begin
                        mem_accept();
                        bus.mem_ready_i = 1'b1;
                    end else begin
                        mem_cnt--;
                    end
                end
            end
        end
    end

    task automatic mem_mon_t_init();
        bus.mem_ready_i = 1'b0;
        bus.mem_data_i  = '0;
    endtask

    task automatic mem_accept();
        mem_exp_t e;
        int line;
        line = int'(bus.mem_req_addr_o >> 4);
        if (mem_q.size() == 0) begin
            chk(0, "mem_unexpected", {bus.mem_req_rw_o, bus.mem_req_addr_o}, '0);
        end else begin
            e = mem_q.pop_front();
            chk(bus.mem_req_rw_o == e.rw && bus.mem_req_addr_o == e.addr, "mem_order",
                {bus.mem_req_rw_o, bus.mem_req_addr_o}, {e.rw, e.addr});
            if (e.rw) chk(bus.mem_req_data_o == e.data, "mem_wdata", bus.mem_req_data_o, e.data);
            $display("mem %s addr=%08h data=%0h", bus.mem_req_rw_o ? "WR" : "RD", bus.mem_req_addr_o, bus.mem_req_data_o);
        end
        if (bus.mem_req_rw_o) mem_store[line] = bus.mem_req_data_o;
        else bus.mem_data_i = mem_store.exists(line) ? mem_store[line] : dflt(line);
    endtask

    // Cache-side monitor: every completion pulse must match the next expected response.
    initial begin : cache_mon
        cache_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.cache_ready_o) begin
                if (cache_q.size() == 0) begin
                    chk(0, "cache_unexpected_ready", bus.cache_data_o, '0);
                end else begin
                    e = cache_q.pop_front();
                    if (e.is_rd) chk(bus.cache_data_o == e.data, e.name, bus.cache_data_o, e.data);
                    $display("cache %s done data=%0h", e.name, bus.cache_data_o);
                end
            end
        end
    end

    task automatic push_wr(input logic [31:0] addr, input logic [127:0] data);
        mem_exp_t e;
        e.rw = 1; e.addr = addr & 32'hffff_fff0; e.data = data;
        mem_q.push_back(e);
        ref_mem[int'(addr >> 4)] = data;
    endtask

    task automatic push_rd(input logic [31:0] addr);
        mem_exp_t e;
        e.rw = 0; e.addr = addr; e.data = '0;
        mem_q.push_back(e);
    endtask

    // exp_lat: 0 = unchecked, -1 = must exceed one cycle, otherwise exact cycles to ready.
    task automatic cache_op(input logic rw, input logic [31:0] addr, input logic [127:0] data,
                            input logic [127:0] exp, input int exp_lat, input string name);
        cache_exp_t e;
        int lat;
        bit seen;
        e.is_rd = !rw; e.data = exp; e.name = name;
        cache_q.push_back(e);
        bus.cache_req_valid_i = 1'b1;
        bus.cache_req_rw_i    = rw;
        bus.cache_req_addr_i  = addr;
        bus.cache_req_data_i  = data;
        lat = 0;
        seen = 0;
        while (!seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (bus.cache_ready_o) seen = 1;
        end
        if (!seen) chk(0, {name, "_timeout"}, lat, 200);
        else if (exp_lat > 0) chk(lat == exp_lat, {name, "_latency"}, lat, exp_lat);
        else if (exp_lat < 0) chk(lat > 1, {name, "_latency_gt1"}, lat, 2);
        @(posedge clk); #1;
        bus.cache_req_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (n < 400 && !(dut.r_count == 0 && !bus.mem_req_valid_o && !bus.mem_ready_i)) begin
            @(posedge clk); #1;
            n++;
        end
        chk(dut.r_count == 0 && !bus.mem_req_valid_o, {name, "_drain"}, dut.r_count, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nvalid;
        bus.cache_req_valid_i = 1'b0;
        bus.cache_req_rw_i    = 1'b0;
        bus.cache_req_addr_i  = '0;
        bus.cache_req_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(bus.cache_ready_o == 0, "rst_cache_ready", bus.cache_ready_o, 0);
        chk(bus.mem_req_valid_o == 0, "rst_mem_valid", bus.mem_req_valid_o, 0);
        chk(bus.mem_req_addr_o == 0, "rst_mem_addr", bus.mem_req_addr_o, 0);
        chk(dut.r_count == 0, "rst_count", dut.r_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write, then background drain.
        mem_delay = 4;
        push_wr(32'h4000, 128'h1234_abcd);
        cache_op(1, 32'h4000, 128'h1234_abcd, '0, 1, "t1_wr");
        chk(dut.r_count == 1, "t1_count", dut.r_count, 1);
        wait_drain("t1");

        // DEPTH+1 distinct lines: the fifth write stalls until the first drain completes.
        mem_delay = 8;
        for (int k = 0; k < 5; k++) begin
            push_wr(32'(k * 16), 128'h2000_0000 + 128'(k));
            cache_op(1, 32'(k * 16), 128'h2000_0000 + 128'(k), '0, (k == 4) ? 3 : 1, $sformatf("t2_wr%0d", k));
        end
        chk(dut.r_count == 4, "t2_count_after_stall", dut.r_count, 4);
        wait_drain("t2");

        // Coalescing while the head line is in flight.
        mem_delay = 10;
        push_wr(32'h0100, 128'haaaa);
        push_wr(32'h0040, 128'h2222);
        cache_op(1, 32'h0100, 128'haaaa, '0, 1, "t3_wr100");
        cache_op(1, 32'h0040, 128'h1111, '0, 1, "t3_wr40a");
        cache_op(1, 32'h0040, 128'h2222, '0, 1, "t3_wr40b");
        chk(dut.r_count == 2, "t3_count_coalesce", dut.r_count, 2);
        wait_drain("t3");

        // Read of a line still queued.
        mem_delay = 10;
        push_wr(32'h4000, 128'habcd);
        cache_op(1, 32'h4000, 128'habcd, '0, 1, "t4_wr");
`ifdef WB_FORWARD_EN
        cache_op(0, 32'h4004, '0, 128'habcd, 1, "t4_rd_fwd");
`else
        push_rd(32'h4004);
        cache_op(0, 32'h4004, '0, 128'habcd, -1, "t4_rd_mem");
`endif
        wait_drain("t4");

        // Read miss with two queued writes.
        mem_delay = 10;
`ifdef WB_FORWARD_EN
        push_wr(32'h0100, 128'hb1);
        push_rd(32'h0008);
        push_wr(32'h0110, 128'hb2);
`else
        push_wr(32'h0100, 128'hb1);
        push_wr(32'h0110, 128'hb2);
        push_rd(32'h0008);
`endif
        cache_op(1, 32'h0100, 128'hb1, '0, 1, "t5_wr100");
        cache_op(1, 32'h0110, 128'hb2, '0, 1, "t5_wr110");
        cache_op(0, 32'h0008, '0, ref_mem[0], 0, "t5_rd_miss");
        wait_drain("t5");

        // Reset during a drain with three lines queued.
        mem_delay = 20;
        cache_op(1, 32'h0200, 128'hc0, '0, 1, "t6_wr0");
        cache_op(1, 32'h0210, 128'hc1, '0, 1, "t6_wr1");
        cache_op(1, 32'h0220, 128'hc2, '0, 1, "t6_wr2");
        chk(dut.r_count == 3, "t6_count_before_rst", dut.r_count, 3);
        chk(bus.mem_req_valid_o == 1, "t6_wr_in_flight", bus.mem_req_valid_o, 1);
        rst = 1'b1;
        #1;
        chk(bus.mem_req_valid_o == 0 && bus.mem_req_rw_o == 0, "t6_rst_mem_ctl", {bus.mem_req_valid_o, bus.mem_req_rw_o}, 0);
        chk(bus.mem_req_addr_o == 0, "t6_rst_mem_addr", bus.mem_req_addr_o, 0);
        chk(bus.mem_req_data_o == 0, "t6_rst_mem_data", bus.mem_req_data_o, 0);
        chk(bus.cache_ready_o == 0 && bus.cache_data_o == 0, "t6_rst_cache", bus.cache_data_o, 0);
        chk(dut.r_count == 0, "t6_rst_count", dut.r_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nvalid = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.mem_req_valid_o) nvalid++;
        end
        chk(nvalid == 0, "t6_no_mem_after_rst", nvalid, 0);

        chk(cache_q.size() == 0, "cache_q_empty", cache_q.size(), 0);
        chk(mem_q.size() == 0, "mem_q_empty", mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
